oflow_pe_registration: RTL
==========================

# oflow_pe_registration

Per-PE registration and score engine, the responder side of the core's registration handshake. It receives a one-cycle `start_registration` or `not_start_registration` strobe from the core registration FSM. On start, it registers the current bbox into the PE's history write port. For frames other than frame 0 it then scores the bbox against the previous-frame candidates. It raises level `done_registration` and `done_score_calc` flags, which the core ANDs across all active PEs. One instance sits in each of the `PE_NUM` PEs.

## Interface
- `CENTER_W`, 11: width of each centroid coordinate.
- `CAND_NUM`, 24: maximum previous-frame candidates per PE.
- `CAND_ADDR_W`, 5: width of the candidate index; `2**CAND_ADDR_W >= CAND_NUM`.
- `ID_W`, 12: width of the bbox ID.
- `clk` in 1: single clock, rising edge.
- `reset_N` in 1: reset, synchronous, active-high (1 = reset), sampled on `clk`.
- `start_registration` in 1: one-cycle start strobe from the core.
- `not_start_registration` in 1: one-cycle strobe meaning "PE unused this set".
- `frame_num` in `TOTAL_FRAME_NUM_WIDTH`: current frame; 0 means registration only.
- `cur_x`, `cur_y` in `CENTER_W` each: current bbox centroid, valid with the start strobe.
- `cur_id` in `ID_W`: current bbox ID, valid with the start strobe.
- `cand_count` in `CAND_ADDR_W+1`: number of valid candidates, 0..`CAND_NUM`, sampled with the start strobe.
- `hist_we` out 1: history write enable.
- `hist_wdata` out `2*CENTER_W+ID_W`: written value, `{cur_id, cur_y, cur_x}`.
- `cand_rd_en` out 1: candidate read request.
- `cand_rd_addr` out `CAND_ADDR_W`: candidate index.
- `cand_x`, `cand_y` in `CENTER_W` each: candidate data, returned exactly 1 cycle after `cand_rd_en`.
- `best_score` out `CENTER_W+1`: minimum |dx|+|dy|.
- `best_idx` out `CAND_ADDR_W`: index of the best candidate.
- `best_valid` out 1: at least one candidate was scored.
- `done_registration` out 1: level flag.
- `done_score_calc` out 1: level flag.

## Operation
- **States:** IDLE, REG, SCORE, DRAIN, DONE.
- **Input capture:** on `start_registration` in IDLE or DONE, latch `cur_*`, `cand_count` and `frame_num`, clear both done flags and the result registers, then go to REG.
- **Simultaneous strobes:** if `start_registration` and `not_start_registration` are both high, start wins.
- **`not_start_registration`:** in any state, clears both done flags, `best_valid`, `best_score` and `best_idx`, and goes to IDLE. Any in-flight score is abandoned.
- **REG (1 cycle):**
  - `hist_we=1` with the latched data.
  - Next cycle `done_registration=1`.
  - If the latched `frame_num==0` or `cand_count==0`: go to DONE and set `done_score_calc=1` in the same cycle as `done_registration`. `best_valid=0` and `best_score` is all-ones.
  - Otherwise go to SCORE.
- **SCORE:** issue `cand_rd_en=1`, `cand_rd_addr=k` for k=0..`cand_count`-1, one per cycle. After the last read, go to DRAIN.
- **DRAIN (1 cycle):** consume the final data. Next cycle, DONE with `done_score_calc=1`.
- **Compare pipeline:**
  - Data arriving in cycle k+1 is scored as |`cand_x`-`cur_x`|+|`cand_y`-`cur_y`| at `CENTER_W+1` bits. This cannot overflow.
  - The result replaces the best only if strictly less, so on ties the lower index wins.
  - The first score always loads and sets `best_valid=1`.
- **Start while busy:** `start_registration` in REG, SCORE or DRAIN is ignored; the operation continues.
- **DONE:**
  - Both flags and all results hold until the next strobe or reset.
  - A start in DONE clears the flags in the cycle after the strobe. The core never sees stale 1s after it has issued a start.

## Timing
- **Reset values:** all outputs 0, except `best_score`, which resets to all-ones. The FSM resets to IDLE.
- **Strobe timing:** strobe at edge t means REG during cycle t+1 and `done_registration` high from t+2.
- **Score latency:** with N=`cand_count`>0 and frame≠0, reads occur in cycles t+2..t+N+1. DRAIN is in cycle t+N+2. `done_score_calc` and the final results are visible from t+N+3.
- **Frame 0 or N=0:** both flags rise together at t+2.
- **Reset mid-operation:** immediate IDLE. No `hist_we` or `cand_rd_en` in the reset cycle or the cycle after it.

## Structure
- `TOTAL_FRAME_NUM_WIDTH`, `PE_NUM` and the state enum `pe_reg_state_t` go in the shared core package or define file.
- One natural sub-module, `oflow_pe_score_cmp`: registered abs-diff sum plus min/argmin tracker, with `clear`, `valid_in`, `idx_in` inputs.

## Test plan
- **Frame 0:** `frame_num=0`, start with (100,200,id 7) → one `hist_we` with `{7,200,100}` at t+1; both flags high at t+2; `best_valid=0`.
- **Frame 3, three candidates:** `frame_num=3`, `cand_count=3`, `cur=(50,50)`, candidates (60,50), (52,49), (40,40) → reads at t+2..t+4; `done_score_calc` at t+6; `best_score=3`, `best_idx=1`.
- **Tie:** candidates (55,50), (45,50) → `best_score=5`, `best_idx=0`.
- **`not_start_registration` mid-SCORE:** flags and `best_valid` return to 0 next cycle; no further `cand_rd_en`.
- **Restart from DONE, plus busy start:** start from DONE → `done_registration` is 0 at t+1 and rises at t+2. A second start while in SCORE is ignored; the read count equals `cand_count`.
- **Reset mid-operation:** `reset_N=1` during SCORE → all outputs at reset values next cycle; a fresh start then behaves normally.

Source files
------------

// File: rtl/oflow_pe_registration_pkg.sv
// Shared definitions for the per-PE registration/score engine.
package oflow_pe_registration_pkg;

  localparam int TOTAL_FRAME_NUM_WIDTH = 16;
  localparam int PE_NUM                = 16;

  typedef enum logic [2:0] {
    PE_IDLE  = 3'd0,
    PE_REG   = 3'd1,
    PE_SCORE = 3'd2,
    PE_DRAIN = 3'd3,
    PE_DONE  = 3'd4
  } pe_reg_state_t;

endpackage

// File: rtl/oflow_pe_score_cmp.sv
// Manhattan-distance scorer with a running min/argmin; ties keep the earlier index.
module oflow_pe_score_cmp #(
  parameter int CENTER_W    = 11,
  parameter int CAND_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   valid_in,
  input  logic [CAND_ADDR_W-1:0] idx_in,
  input  logic [CENTER_W-1:0]    cand_x,
  input  logic [CENTER_W-1:0]    cand_y,
  input  logic [CENTER_W-1:0]    cur_x,
  input  logic [CENTER_W-1:0]    cur_y,
  output logic [CENTER_W:0]      best_score,
  output logic [CAND_ADDR_W-1:0] best_idx,
  output logic                   best_valid
);

  logic [CENTER_W:0]      best_score_q, best_score_d;
  logic [CAND_ADDR_W-1:0] best_idx_q, best_idx_d;
  logic                   best_valid_q, best_valid_d;
  logic [CENTER_W:0]      score;

  function automatic logic [CENTER_W-1:0] abs_diff(input logic [CENTER_W-1:0] a,
                                                   input logic [CENTER_W-1:0] b);
    logic signed [CENTER_W:0] d;
    logic signed [CENTER_W:0] m;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    m = (d < 0) ? -d : d;
    return m[CENTER_W-1:0];
  endfunction

  // Sum of two W-bit magnitudes always fits in W+1 bits.
  assign score = {1'b0, abs_diff(cand_x, cur_x)} + {1'b0, abs_diff(cand_y, cur_y)};

  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    if (clear) begin
      best_score_d = '1;
      best_idx_d   = '0;
      best_valid_d = 1'b0;
    end else if (valid_in && (!best_valid_q || (score < best_score_q))) begin
      best_score_d = score;
      best_idx_d   = idx_in;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= '1;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_score = best_score_q;
  assign best_idx   = best_idx_q;
  assign best_valid = best_valid_q;

endmodule

// File: rtl/oflow_pe_registration.sv
// Per-PE registration responder: writes the current bbox to history, then scores it
// against the previous-frame candidates and reports level done flags to the core.
module oflow_pe_registration
  import oflow_pe_registration_pkg::*;
#(
  parameter int CENTER_W    = 11,
  parameter int CAND_NUM    = 24,
  parameter int CAND_ADDR_W = 5,
  parameter int ID_W        = 12
) (
  input  logic                             clk,
  input  logic                             reset_N,
  input  logic                             start_registration,
  input  logic                             not_start_registration,
  input  logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num,
  input  logic [CENTER_W-1:0]              cur_x,
  input  logic [CENTER_W-1:0]              cur_y,
  input  logic [ID_W-1:0]                  cur_id,
  input  logic [CAND_ADDR_W:0]             cand_count,
  output logic                             hist_we,
  output logic [2*CENTER_W+ID_W-1:0]       hist_wdata,
  output logic                             cand_rd_en,
  output logic [CAND_ADDR_W-1:0]           cand_rd_addr,
  input  logic [CENTER_W-1:0]              cand_x,
  input  logic [CENTER_W-1:0]              cand_y,
  output logic [CENTER_W:0]                best_score,
  output logic [CAND_ADDR_W-1:0]           best_idx,
  output logic                             best_valid,
  output logic                             done_registration,
  output logic                             done_score_calc
);

  pe_reg_state_t          state_q, state_d;
  logic [CENTER_W-1:0]    cur_x_q, cur_x_d;
  logic [CENTER_W-1:0]    cur_y_q, cur_y_d;
  logic [ID_W-1:0]        cur_id_q, cur_id_d;
  logic [CAND_ADDR_W:0]   cnt_q, cnt_d;
  logic                   score_en_q, score_en_d;
  logic [CAND_ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic                   rd_vld_q, rd_vld_d;
  logic [CAND_ADDR_W-1:0] rd_vld_idx_q, rd_vld_idx_d;
  logic                   done_reg_q, done_reg_d;
  logic                   done_score_q, done_score_d;
  logic                   cmp_clear;
  logic                   start_acc;
  logic [CAND_ADDR_W:0]   last_idx;

  assign start_acc = start_registration && ((state_q == PE_IDLE) || (state_q == PE_DONE));
  assign last_idx  = cnt_q - {{CAND_ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_id_d     = cur_id_q;
    cnt_d        = cnt_q;
    score_en_d   = score_en_q;
    rd_idx_d     = rd_idx_q;
    rd_vld_d     = 1'b0;
    rd_vld_idx_d = rd_idx_q;
    done_reg_d   = done_reg_q;
    done_score_d = done_score_q;
    cmp_clear    = 1'b0;

    if (start_acc) begin
      cur_x_d      = cur_x;
      cur_y_d      = cur_y;
      cur_id_d     = cur_id;
      cnt_d        = cand_count;
      score_en_d   = (frame_num != '0) && (cand_count != '0);
      rd_idx_d     = '0;
      done_reg_d   = 1'b0;
      done_score_d = 1'b0;
      cmp_clear    = 1'b1;
      state_d      = PE_REG;
    end else if (not_start_registration && !start_registration) begin
      // Abandons any in-flight read; the pending data beat is dropped too.
      rd_idx_d     = '0;
      done_reg_d   = 1'b0;
      done_score_d = 1'b0;
      cmp_clear    = 1'b1;
      state_d      = PE_IDLE;
    end else begin
      unique case (state_q)
        PE_REG: begin
          done_reg_d = 1'b1;
          if (score_en_q) begin
            state_d = PE_SCORE;
          end else begin
            done_score_d = 1'b1;
            state_d      = PE_DONE;
          end
        end
        PE_SCORE: begin
          rd_vld_d     = 1'b1;
          rd_vld_idx_d = rd_idx_q;
          if ({1'b0, rd_idx_q} == last_idx) begin
            rd_idx_d = '0;
            state_d  = PE_DRAIN;
          end else begin
            rd_idx_d = rd_idx_q + CAND_ADDR_W'(1);
          end
        end
        PE_DRAIN: begin
          done_score_d = 1'b1;
          state_d      = PE_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q      <= PE_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_id_q     <= '0;
      cnt_q        <= '0;
      score_en_q   <= 1'b0;
      rd_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_vld_idx_q <= '0;
      done_reg_q   <= 1'b0;
      done_score_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_id_q     <= cur_id_d;
      cnt_q        <= cnt_d;
      score_en_q   <= score_en_d;
      rd_idx_q     <= rd_idx_d;
      rd_vld_q     <= rd_vld_d;
      rd_vld_idx_q <= rd_vld_idx_d;
      done_reg_q   <= done_reg_d;
      done_score_q <= done_score_d;
    end
  end

  oflow_pe_score_cmp #(
    .CENTER_W    (CENTER_W),
    .CAND_ADDR_W (CAND_ADDR_W)
  ) u_cmp (
    .clk        (clk),
    .rst        (reset_N),
    .clear      (cmp_clear),
    .valid_in   (rd_vld_q),
    .idx_in     (rd_vld_idx_q),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .cur_x      (cur_x_q),
    .cur_y      (cur_y_q),
    .best_score (best_score),
    .best_idx   (best_idx),
    .best_valid (best_valid)
  );

  // Strobes are masked while reset is held so nothing leaks out in the reset cycle.
  assign hist_we           = (state_q == PE_REG) && !reset_N;
  assign cand_rd_en        = (state_q == PE_SCORE) && !reset_N;
  assign cand_rd_addr      = rd_idx_q;
  assign hist_wdata        = {cur_id_q, cur_y_q, cur_x_q};
  assign done_registration = done_reg_q;
  assign done_score_calc   = done_score_q;

endmodule
